// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, reset address, FSM states.
package ifu_fetch_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
  localparam logic [31:0] START_ADDR   = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry holding register for a fetch response that arrived while IF/ID was stalled.
module fetch_hold_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              err_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o,
  output logic              valid_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= '0;
      addr_o  <= '0;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
    end else if (clear) begin
      valid_o <= 1'b0;
    end else if (load) begin
      data_o  <= data_i;
      addr_o  <= addr_i;
      err_o   <= err_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: single-outstanding request/grant/response on the instruction bus,
// delivers instructions to IF/ID and holds the PC until the current fetch is accepted.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              id_stall_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              fetch_err_o,
  output logic              stall_req_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_load;
  logic              deliver_mem, deliver_hold, accept;
  logic              hold_load, hold_clear;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_err, hold_valid;

  // Errored responses are replaced by a NOP before reaching the hold buffer or outputs.
  assign rsp_data = mem_err_i ? NOP_INST : mem_rdata_i;

  fetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .clear   (hold_clear),
    .data_i  (rsp_data),
    .addr_i  (addr_q),
    .err_i   (mem_err_i),
    .data_o  (hold_data),
    .addr_o  (hold_addr),
    .err_o   (hold_err),
    .valid_o (hold_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_W'(START_ADDR);
    end else begin
      state_q <= state_d;
      if (addr_load) addr_q <= pc_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_addr_o   = addr_q;
    addr_load    = 1'b0;
    deliver_mem  = 1'b0;
    deliver_hold = 1'b0;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_req_o  = ce_i & ~flush_i;
        mem_addr_o = pc_i;
        if (mem_req_o && mem_gnt_i) begin
          addr_load = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (flush_i) begin
            state_d = ST_IDLE;
          end else if (id_stall_i) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            deliver_mem = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (flush_i) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (mem_rvalid_i) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (flush_i) begin
          hold_clear = 1'b1;
          state_d    = ST_IDLE;
        end else if (!id_stall_i && hold_valid) begin
          deliver_hold = 1'b1;
          hold_clear   = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept      = deliver_mem | deliver_hold;
  assign stall_req_o = ce_i & ~accept;

  // Outputs move only when IF/ID can take them or on flush; an idle unstalled cycle retires valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= ADDR_W'(START_ADDR);
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else if (flush_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else if (!id_stall_i) begin
      if (deliver_mem) begin
        inst_o       <= rsp_data;
        inst_addr_o  <= addr_q;
        fetch_err_o  <= mem_err_i;
        inst_valid_o <= 1'b1;
      end else if (deliver_hold) begin
        inst_o       <= hold_data;
        inst_addr_o  <= hold_addr;
        fetch_err_o  <= hold_err;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        fetch_err_o  <= 1'b0;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a scoreboard of expected deliveries and a negedge monitor.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        ce_i, flush_i, id_stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o, fetch_err_o, stall_req_o;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ifu_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NOP_INST (32'h00000013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .fetch_err_o  (fetch_err_o),
    .stall_req_o  (stall_req_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Drive point: 1 time unit after the rising edge; combinational checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_bus();
    ce_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid_o && !id_stall_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst got addr=%h inst=%h want none t=%0t", inst_addr_o, inst_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst_o, e.inst);
        chk("sb_addr", inst_addr_o, e.addr);
        chk("sb_err", {31'd0, fetch_err_o}, {31'd0, e.err});
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc_i = '0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", inst_o, NOP);
    chk("rst_addr", inst_addr_o, 32'h0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_err", {31'd0, fetch_err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back fetches at 0x0 and 0x4, immediate grant, response one cycle later.
    ce_i = 1'b1; pc_i = 32'h0; mem_gnt_i = 1'b1; settle();
    chk("b2b_req0", {31'd0, mem_req_o}, 32'd1);
    chk("b2b_addr0", mem_addr_o, 32'h0);
    chk("b2b_stall0", {31'd0, stall_req_o}, 32'd1);
    exp_q.push_back('{inst: 32'hAAAA0001, addr: 32'h0, err: 1'b0});
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001; settle();
    chk("b2b_stall1", {31'd0, stall_req_o}, 32'd0);
    chk("b2b_noreq1", {31'd0, mem_req_o}, 32'd0);
    step();
    mem_rvalid_i = 1'b0; pc_i = 32'h4; mem_gnt_i = 1'b1; settle();
    chk("b2b_valid2", {31'd0, inst_valid_o}, 32'd1);
    chk("b2b_addr2", mem_addr_o, 32'h4);
    exp_q.push_back('{inst: 32'hAAAA0005, addr: 32'h4, err: 1'b0});
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0005; settle();
    chk("b2b_stall3", {31'd0, stall_req_o}, 32'd0);
    chk("b2b_valid3", {31'd0, inst_valid_o}, 32'd0);
    step();
    idle_bus(); settle();
    chk("b2b_valid4", {31'd0, inst_valid_o}, 32'd1);
    repeat (2) step();

    // Grant withheld for 3 cycles at 0x8: request and address stay put.
    ce_i = 1'b1; pc_i = 32'h8;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3); settle();
      chk("gw_req", {31'd0, mem_req_o}, 32'd1);
      chk("gw_addr", mem_addr_o, 32'h8);
      chk("gw_stall", {31'd0, stall_req_o}, 32'd1);
      step();
    end
    exp_q.push_back('{inst: 32'hBBBB0008, addr: 32'h8, err: 1'b0});
    mem_gnt_i = 1'b0; settle();
    chk("gw_wait_req", {31'd0, mem_req_o}, 32'd0);
    chk("gw_wait_stall", {31'd0, stall_req_o}, 32'd1);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBBBB0008; settle();
    chk("gw_rv_stall", {31'd0, stall_req_o}, 32'd0);
    step();
    idle_bus();
    repeat (2) step();

    // Flush in WAIT; the late response is dropped, next fetch comes from 0x100.
    ce_i = 1'b1; pc_i = 32'h10; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; flush_i = 1'b1; settle();
    chk("fl_stall", {31'd0, stall_req_o}, 32'd1);
    step();
    flush_i = 1'b0; pc_i = 32'h100; mem_gnt_i = 1'b1; settle();
    chk("fl_drop_req", {31'd0, mem_req_o}, 32'd0);
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD0010; settle();
    chk("fl_drop_stall", {31'd0, stall_req_o}, 32'd1);
    step();
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; settle();
    chk("fl_new_req", {31'd0, mem_req_o}, 32'd1);
    chk("fl_new_addr", mem_addr_o, 32'h100);
    exp_q.push_back('{inst: 32'hCCCC0100, addr: 32'h100, err: 1'b0});
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCCCC0100;
    step();
    idle_bus();
    repeat (2) step();

    // Flush together with grant in IDLE: no transaction starts.
    ce_i = 1'b1; pc_i = 32'h20; flush_i = 1'b1; mem_gnt_i = 1'b1; settle();
    chk("flg_req", {31'd0, mem_req_o}, 32'd0);
    step();
    flush_i = 1'b0; mem_gnt_i = 1'b1; settle();
    chk("flg_idle_req", {31'd0, mem_req_o}, 32'd1);
    step();
    // Now in WAIT: flush with rvalid discards the data and returns to IDLE.
    mem_gnt_i = 1'b0; flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD0020;
    step();
    flush_i = 1'b0; mem_rvalid_i = 1'b0; pc_i = 32'h24; settle();
    chk("flr_idle_req", {31'd0, mem_req_o}, 32'd1);
    chk("flr_idle_addr", mem_addr_o, 32'h24);
    chk("flr_valid", {31'd0, inst_valid_o}, 32'd0);
    idle_bus();
    repeat (2) step();

    // Response while IF/ID stalled for 3 cycles: captured in HOLD, delivered after release.
    ce_i = 1'b1; pc_i = 32'h30; mem_gnt_i = 1'b1;
    step();
    exp_q.push_back('{inst: 32'hEEEE0030, addr: 32'h30, err: 1'b0});
    mem_gnt_i = 1'b0; id_stall_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hEEEE0030; settle();
    chk("hd_stall_rv", {31'd0, stall_req_o}, 32'd1);
    step();
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("hd_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("hd_req", {31'd0, mem_req_o}, 32'd0);
      chk("hd_stall", {31'd0, stall_req_o}, 32'd1);
      step();
    end
    id_stall_i = 1'b0; settle();
    chk("hd_accept", {31'd0, stall_req_o}, 32'd0);
    step();
    ce_i = 1'b0; settle();
    chk("hd_out_valid", {31'd0, inst_valid_o}, 32'd1);
    repeat (2) step();

    // Bus error at 0xC: NOP with fetch_err_o, still valid.
    ce_i = 1'b1; pc_i = 32'hC; mem_gnt_i = 1'b1;
    step();
    exp_q.push_back('{inst: NOP, addr: 32'hC, err: 1'b1});
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h12345678; settle();
    chk("err_stall", {31'd0, stall_req_o}, 32'd0);
    step();
    idle_bus();
    repeat (2) step();

    // Reset while WAIT; a stray response afterwards must be ignored.
    ce_i = 1'b1; pc_i = 32'h40; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; ce_i = 1'b0; rst_n = 1'b0; settle();
    chk("rw_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rw_inst", inst_o, NOP);
    step();
    rst_n = 1'b1;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000099;
    step();
    mem_rvalid_i = 1'b0; settle();
    chk("rw_stray_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rw_stray_inst", inst_o, NOP);
    chk("rw_stray_addr", inst_addr_o, 32'h0);
    chk("rw_stray_err", {31'd0, fetch_err_o}, 32'd0);
    chk("rw_stray_req", {31'd0, mem_req_o}, 32'd0);
    repeat (3) step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch responder between the PC register and the instruction memory bus. Consumes the fetch address and fetch enable, runs a single-outstanding request/grant/response transaction on the instruction port, and delivers the instruction with its address to the IF/ID stage. Raises a stall request to ctrl until the current PC's instruction is accepted, so the PC advances exactly once per delivered instruction. Drops wrong-path responses on branch redirect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, instruction width
- NOP_INST, 32'h00000013, instruction emitted on reset, flush or bus error
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_i  in  ADDR_W  fetch address from PC register
- ce_i  in  1  fetch enable from PC register
- flush_i  in  1  branch redirect from ex; pc_i changes next cycle
- id_stall_i  in  1  IF/ID cannot accept this cycle
- mem_req_o  out  1  request valid
- mem_addr_o  out  ADDR_W  request address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  DATA_W  response data
- mem_err_i  in  1  response error, qualified by mem_rvalid_i
- inst_o  out  DATA_W  instruction to IF/ID
- inst_addr_o  out  ADDR_W  address of inst_o
- inst_valid_o  out  1  inst_o valid
- fetch_err_o  out  1  inst_o came from an errored response
- stall_req_o  out  1  hold PC register

## Operation
- States: IDLE, WAIT (response owed, keep), DROP (response owed, discard), HOLD (response captured, IF/ID stalled).
- IDLE: mem_req_o = ce_i & ~flush_i, mem_addr_o = pc_i (combinational). On req & gnt: latch addr → WAIT.
- WAIT: on rvalid & ~flush_i & ~id_stall_i: load output regs → IDLE. On rvalid & ~flush_i & id_stall_i: capture into hold reg → HOLD. On flush_i without rvalid → DROP. On flush_i with rvalid: discard → IDLE.
- DROP: on rvalid discard → IDLE; flush_i ignored.
- HOLD: on ~id_stall_i move hold reg to outputs → IDLE; flush_i clears hold → IDLE.
- Output regs update only when ~id_stall_i or flush_i; otherwise hold. flush_i forces inst_valid_o=0, inst_o=NOP_INST next edge.
- Error response: inst_o=NOP_INST, fetch_err_o=1, inst_valid_o=1; pipeline does not stall on errors.
- stall_req_o = ce_i & ~accept, accept = (WAIT & rvalid & ~flush_i & ~id_stall_i) | (HOLD & ~id_stall_i). Combinational, no path from pc_i.
- Only one outstanding transaction; mem_req_o=0 in WAIT, DROP, HOLD.

## Timing
- Reset: state IDLE, mem_req_o follows ce_i (0 during reset), inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, fetch_err_o=0, stall_req_o=0.
- Reset mid-transaction: state IDLE; a later stray rvalid in IDLE is ignored.
- Best case: req+gnt cycle N, rvalid N+1, stall_req_o low N+1, PC advances at end of N+1, inst_valid_o high N+2. Throughput one instruction per 2 cycles.
- Gnt wait: request and address held stable while ~gnt; pc_i stable since stall_req_o=1.
- flush_i and gnt same cycle in IDLE: mem_req_o already 0, no transaction.
- flush_i and rvalid same cycle: data never reaches outputs.
- ce_i low: no new request; in-flight response still completes normally.

## Structure
- NOP_INST, state encodings, StartAdd-compatible reset address belong in yadan_defs.v.
- One natural sub-module: fetch_hold_buf (single-entry data/addr/err register with load/clear/valid).

## Test plan
- Back-to-back: pc 0x0,0x4, gnt immediate, rvalid +1 → inst_valid_o at cycles 2 and 4, inst_addr_o 0x0 then 0x4, stall_req_o low cycles 1,3.
- Gnt delayed 3 cycles at pc 0x8 → mem_addr_o=0x8 stable all 4 cycles, stall_req_o high until rvalid cycle.
- flush_i in WAIT, rvalid 2 cycles later, new pc 0x100 → old data dropped, next inst_addr_o=0x100.
- rvalid with id_stall_i high 3 cycles → HOLD, inst_valid_o unchanged, data delivered cycle after stall drops.
- mem_err_i with rvalid at pc 0xC → inst_o=0x00000013, fetch_err_o=1, inst_addr_o=0xC.
- rst_n low in WAIT, stray rvalid after release → no inst_valid_o, outputs at reset values.
